// File: rtl/arch_rfl_pkg.sv
// arch_rfl_pkg: rename constants and free-list pointer helpers, shared with the speculative free list.
`default_nettype none

package arch_rfl_pkg;

  localparam int NUM_PREG = 80;
  localparam int NUM_AREG = 32;
  localparam int NUM_FREE = NUM_PREG - NUM_AREG;
  localparam int PREG_W   = 7;
  localparam int FL_PTR_W = 6;
  localparam int RET_W    = 8;

  typedef logic [PREG_W-1:0]   preg_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;
  typedef logic [FL_PTR_W:0]   fl_sum_t;
  typedef logic [3:0]          ret_cnt_t;

  // Circular add on the free-list ring; both operands are below NUM_FREE.
  function automatic fl_ptr_t fl_ptr_add(input fl_ptr_t ptr, input fl_ptr_t inc);
    fl_sum_t s;
    s = {1'b0, ptr} + {1'b0, inc};
    if (s >= fl_sum_t'(NUM_FREE)) s = s - fl_sum_t'(NUM_FREE);
    return s[FL_PTR_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/arch_rfl_compact.sv
// arch_rfl_compact: prefix count of committing retire slots (per-slot offset and total).
`default_nettype none

module arch_rfl_compact
  import arch_rfl_pkg::*;
(
  input  logic [RET_W-1:0]           i_commit,
  output ret_cnt_t [RET_W-1:0]       o_ofs,
  output ret_cnt_t                   o_cnt
);

  ret_cnt_t w_acc;

  always_comb begin
    w_acc = '0;
    o_ofs = '0;
    for (int i = 0; i < RET_W; i++) begin
      o_ofs[i] = w_acc;
      w_acc    = w_acc + ret_cnt_t'(i_commit[i]);
    end
    o_cnt = w_acc;
  end

endmodule

`default_nettype wire

// File: rtl/arch_rfl.sv
// arch_rfl: architectural (committed) free list with retire release ports and flush snapshot.
// Optional allocation-order checker enabled by defining ARCH_RFL_CHECK_EN.
`default_nettype none

module arch_rfl
  import arch_rfl_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [RET_W-1:0]             ret_vld_i,
  input  logic [RET_W-1:0]             ret_rd_vld_i,
  input  logic [RET_W*PREG_W-1:0]      ret_prev_pr_i,
  input  logic [RET_W*PREG_W-1:0]      ret_new_pr_i,
  input  logic                         flush_i,
  output logic [RET_W*PREG_W-1:0]      retire_rls_rd_o,
  output logic [RET_W-1:0]             retire_rls_rd_vld_o,
  output logic                         arch_fl_rec_o,
  output logic [NUM_FREE*PREG_W-1:0]   arch_fl_rec_data_o,
  output logic                         arch_rfl_err_o
);

  preg_t                     r_mem [NUM_FREE];
  fl_ptr_t                   r_head;
  fl_ptr_t                   r_tail;
  fl_ptr_t                   r_count;
  logic [RET_W-1:0]          r_rls_vld;
  logic [RET_W*PREG_W-1:0]   r_rls_rd;
  logic                      r_rec;

  logic [RET_W-1:0]          w_commit;
  ret_cnt_t [RET_W-1:0]      w_ofs;
  ret_cnt_t                  w_cnt;
  fl_ptr_t [RET_W-1:0]       w_widx;

  assign w_commit = ret_vld_i & ret_rd_vld_i;

  arch_rfl_compact u_compact (
    .i_commit (w_commit),
    .o_ofs    (w_ofs),
    .o_cnt    (w_cnt)
  );

  always_comb begin
    for (int i = 0; i < RET_W; i++) begin
      w_widx[i] = fl_ptr_add(r_tail, fl_ptr_t'(w_ofs[i]));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= fl_ptr_t'(NUM_FREE);
      r_rls_vld <= '0;
      r_rls_rd  <= '0;
      r_rec     <= 1'b0;
      for (int j = 0; j < NUM_FREE; j++) begin
        r_mem[j] <= preg_t'(NUM_AREG + j);
      end
    end else begin
      for (int i = 0; i < RET_W; i++) begin
        if (w_commit[i]) r_mem[w_widx[i]] <= ret_prev_pr_i[i*PREG_W +: PREG_W];
        r_rls_rd[i*PREG_W +: PREG_W] <= w_commit[i] ? ret_prev_pr_i[i*PREG_W +: PREG_W] : '0;
      end
      r_rls_vld <= w_commit;
      r_head    <= fl_ptr_add(r_head, fl_ptr_t'(w_cnt));
      r_tail    <= fl_ptr_add(r_tail, fl_ptr_t'(w_cnt));
      // Every commit frees one register and consumes one, so occupancy never moves.
      r_count   <= r_count;
      r_rec     <= flush_i;
    end
  end

  always_comb begin
    arch_fl_rec_data_o = '0;
    for (int j = 0; j < NUM_FREE; j++) begin
      arch_fl_rec_data_o[j*PREG_W +: PREG_W] = r_mem[fl_ptr_add(r_head, fl_ptr_t'(j))];
    end
  end

  assign retire_rls_rd_o     = r_rls_rd;
  assign retire_rls_rd_vld_o = r_rls_vld;
  assign arch_fl_rec_o       = r_rec;

`ifdef ARCH_RFL_CHECK_EN
  logic r_err;
  logic w_mismatch;

  // The k-th commit must have been allocated from head+k, read before this cycle's writes.
  always_comb begin
    w_mismatch = 1'b0;
    for (int i = 0; i < RET_W; i++) begin
      if (w_commit[i] &&
          ret_new_pr_i[i*PREG_W +: PREG_W] != r_mem[fl_ptr_add(r_head, fl_ptr_t'(w_ofs[i]))])
        w_mismatch = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_err <= 1'b0;
    else          r_err <= r_err | w_mismatch;
  end

  assign arch_rfl_err_o = r_err;
`else
  logic w_unused_new_pr;
  assign w_unused_new_pr = ^ret_new_pr_i;
  assign arch_rfl_err_o  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_arch_rfl.sv
// tb_arch_rfl: randomized scoreboard bench for arch_rfl against a queue-based free-list model.
`default_nettype none

module tb_arch_rfl;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   ret_vld_i = '0;
  logic [7:0]   ret_rd_vld_i = '0;
  logic [55:0]  ret_prev_pr_i = '0;
  logic [55:0]  ret_new_pr_i = '0;
  logic         flush_i = 1'b0;
  logic [55:0]  retire_rls_rd_o;
  logic [7:0]   retire_rls_rd_vld_o;
  logic         arch_fl_rec_o;
  logic [335:0] arch_fl_rec_data_o;
  logic         arch_rfl_err_o;

  arch_rfl dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .ret_vld_i           (ret_vld_i),
    .ret_rd_vld_i        (ret_rd_vld_i),
    .ret_prev_pr_i       (ret_prev_pr_i),
    .ret_new_pr_i        (ret_new_pr_i),
    .flush_i             (flush_i),
    .retire_rls_rd_o     (retire_rls_rd_o),
    .retire_rls_rd_vld_o (retire_rls_rd_vld_o),
    .arch_fl_rec_o       (arch_fl_rec_o),
    .arch_fl_rec_data_o  (arch_fl_rec_data_o),
    .arch_rfl_err_o      (arch_rfl_err_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]   vld;
    logic [55:0]  rd;
    logic         rec;
    logic [335:0] data;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   fl[48];
  int   hd, tl;
  bit   err_m;
  int   checks = 0;
  int   failures = 0;

  task automatic model_reset();
    hd = 0;
    tl = 0;
    err_m = 0;
    for (int j = 0; j < 48; j++) fl[j] = 32 + j;
  endtask

  task automatic chk(input string name, input logic [335:0] act, input logic [335:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One cycle of stimulus; the model computes what the DUT must show after the next edge.
  task automatic step(input logic [7:0] vld, input logic [7:0] rdv, input logic [55:0] prev,
                      input logic flush, input bit bad, input bit rst);
    exp_t        e;
    logic [55:0] newp;
    int          old[48];
    int          k;
    int          want;
    int          nv;
    @(negedge clock);
    e = '0;
    newp = {$urandom, $urandom};
    if (rst) begin
      reset_n = 1'b0;
      model_reset();
    end else begin
      reset_n = 1'b1;
      old = fl;
      k = 0;
      for (int i = 0; i < 8; i++) begin
        if (vld[i] && rdv[i]) begin
          want = old[(hd + k) % 48];
          nv = (bad && k == 0) ? (want + 8) % 128 : want;
          newp[i*7 +: 7] = 7'(nv);
`ifdef ARCH_RFL_CHECK_EN
          if (nv != want) err_m = 1;
`endif
          fl[(tl + k) % 48] = int'(prev[i*7 +: 7]);
          e.vld[i] = 1'b1;
          e.rd[i*7 +: 7] = prev[i*7 +: 7];
          k++;
        end
      end
      hd = (hd + k) % 48;
      tl = (tl + k) % 48;
      e.rec = flush;
      for (int j = 0; j < 48; j++) e.data[j*7 +: 7] = 7'(fl[(hd + j) % 48]);
      e.err = err_m;
    end
    ret_vld_i     = vld;
    ret_rd_vld_i  = rdv;
    ret_prev_pr_i = prev;
    ret_new_pr_i  = newp;
    flush_i       = flush;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rls_vld", 336'(retire_rls_rd_vld_o), 336'(e.vld));
        chk("rls_rd", 336'(retire_rls_rd_o), 336'(e.rd));
        chk("rec", 336'(arch_fl_rec_o), 336'(e.rec));
        chk("err", 336'(arch_rfl_err_o), 336'(e.err));
        if (e.rec) chk("rec_data", arch_fl_rec_data_o, e.data);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [55:0] p;
    int          wait_cyc;
    model_reset();
    repeat (2) @(posedge clock);

    step(8'h00, 8'h00, '0, 1'b0, 0, 0);
    step(8'h00, 8'h00, '0, 1'b1, 0, 0);

    p = {$urandom, $urandom};
    p[0*7 +: 7] = 7'd5;
    p[2*7 +: 7] = 7'd9;
    p[5*7 +: 7] = 7'd17;
    step(8'b0110_0101, 8'b0011_1111, p, 1'b0, 0, 0);
    step(8'h00, 8'h00, '0, 1'b1, 0, 0);

    // Walk head/tail from 3 up to 44, then commit all eight across the wrap.
    repeat (5) step(8'hFF, 8'hFF, {$urandom, $urandom}, 1'b0, 0, 0);
    step(8'h01, 8'h01, {$urandom, $urandom}, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) p[i*7 +: 7] = 7'(i + 1);
    step(8'hFF, 8'hFF, p, 1'b1, 0, 0);

    p = '0;
    p[0 +: 7] = 7'd3;
    p[7 +: 7] = 7'd4;
    step(8'h03, 8'h03, p, 1'b1, 0, 0);

    repeat (3) step(8'h00, 8'h00, '0, 1'b1, 0, 0);

    for (int c = 0; c < 400; c++) begin
      step(8'($urandom), 8'($urandom), {$urandom, $urandom}, ($urandom_range(0, 7) == 0), 0, 0);
    end

    step(8'h01, 8'h01, {$urandom, $urandom}, 1'b0, 0, 0);
    step(8'hFF, 8'hFF, {$urandom, $urandom}, 1'b1, 0, 1);
    step(8'h00, 8'h00, '0, 1'b1, 0, 0);

`ifdef ARCH_RFL_CHECK_EN
    step(8'h01, 8'h01, {$urandom, $urandom}, 1'b0, 1, 0);
    repeat (4) step(8'($urandom), 8'($urandom), {$urandom, $urandom}, 1'b0, 0, 0);
    step(8'h00, 8'h00, '0, 1'b0, 0, 1);
    step(8'h00, 8'h00, '0, 1'b1, 0, 0);
`endif

    step(8'h00, 8'h00, '0, 1'b0, 0, 0);
    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge clock);
      wait_cyc++;
    end
    @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/arch_rfl.md
ARCH_RFL -- requirements
Module: arch_rfl

Interface
REQ-001 SHALL have ports: clock  in  1  core clock; reset_n  in  1  reset.
REQ-002 SHALL state: reset reset_n, asynchronous, active-low; clock clock.
REQ-003 ret_vld_i  in  8  retire slot i valid, in program order, slot 0 oldest.
REQ-004 ret_rd_vld_i  in  8  slot i writes a destination physical register.
REQ-005 ret_prev_pr_i  in  56  7b per slot: previous mapping of rd, now freed.
REQ-006 ret_new_pr_i  in  56  7b per slot: physical register committed to rd.
REQ-007 flush_i  in  1  mispredict/exception recovery request.
REQ-008 retire_rls_rd_o  out  56  7b per port: freed register sent to the speculative free list.
REQ-009 retire_rls_rd_vld_o  out  8  release port i valid.
REQ-010 arch_fl_rec_o  out  1  recovery pulse to the speculative free list.
REQ-011 arch_fl_rec_data_o  out  336  48x7b committed free list, entry 0 = oldest (head).
REQ-012 arch_rfl_err_o  out  1  sticky allocation-order error.

Function
REQ-013 SHALL hold a 48-entry x 7b circular queue, 6b head/tail pointers, wrap 47->0, plus a 6b occupancy count.
- Slot commit = ret_vld_i[i] & ret_rd_vld_i[i]; n = popcount(commits), 0..8.
REQ-014 Per cycle: the k-th committing slot, in slot order, SHALL write ret_prev_pr_i into entry (tail+k) mod 48; tail += n mod 48; head += n mod 48.
- Count stays 48 because each commit frees one register and consumes one.
REQ-015 Release outputs SHALL be registered with 1-cycle latency: retire_rls_rd_vld_o[i] = commit[i] of the previous cycle; data positional per slot.
- Gaps between valid ports are allowed; the consumer compacts them.
REQ-016 Non-committing slots SHALL drive vld 0 and data 7'h00.
REQ-017 flush_i SHALL produce arch_fl_rec_o = 1 exactly one cycle later (single pulse), aligned with that cycle's release outputs.
- Same-cycle retires are applied before the flush snapshot.
REQ-018 arch_fl_rec_data_o SHALL be combinational from the queue, rotated so slice j = mem[(head+j) mod 48]; it is valid whenever arch_fl_rec_o = 1.
REQ-019 flush_i held for multiple cycles SHALL produce one pulse per asserted cycle.
- Queue state is not otherwise altered by a flush.
REQ-020 n = 8 with tail at 44 SHALL wrap writes to entries 44..47 and 0..3 correctly.

Reset
REQ-021 On reset_n low: head = tail = 0, count = 48, mem[j] = 32+j for j = 0..47.
- All outputs 0: vld, data, rec pulse, err.
REQ-022 Reset mid-operation SHALL discard pending registered releases and the pending rec pulse.

Configuration
REQ-023 With ARCH_RFL_CHECK_EN defined: each committing slot's ret_new_pr_i SHALL be compared with mem[(head+k) mod 48]; any mismatch sets arch_rfl_err_o = 1 the next cycle, held until reset.
REQ-024 Without ARCH_RFL_CHECK_EN: no comparator is built and arch_rfl_err_o is tied 0.

Structure
REQ-025 Shared rename package SHALL hold: NUM_PREG = 80, NUM_AREG = 32, NUM_FREE = 48, PREG_W = 7, FL_PTR_W = 6, RET_W = 8.
- The same package constants are used by the speculative free list.
REQ-026 One sub-module, arch_rfl_compact: combinational prefix-count giving each slot's offset k and n.
- Its output feeds both the write-index and pointer-update logic.

Verification
REQ-027 After reset, flush_i = 1 -> next cycle arch_fl_rec_o = 1 and data slice j = 32+j.
REQ-028 Slots 0, 2, 5 commit with prev = 5, 9, 17 -> next cycle vld = 8'b00100101 with ports 0/2/5 = 5/9/17; head = tail = 3.
REQ-029 With head = tail = 44, all 8 slots commit prev = 1..8 -> mem[44..47] = 1..4, mem[0..3] = 5..8; head = tail = 4.
REQ-030 Retire of 2 commits (prev 3, 4) plus flush_i in the same cycle -> rec pulse data has 3 and 4 at slices 46 and 47.
REQ-031 With ARCH_RFL_CHECK_EN, first retire ret_new_pr_i = 40 (expected 32) -> arch_rfl_err_o = 1 next cycle, stays 1 until reset_n pulse.
REQ-032 Assert reset_n low the cycle after a commit -> no release vld is observed and all state returns to reset values.
